rp8_tmr8: RTL
=============

Name: rp8_tmr8

Overview:
- 8-bit timer/counter peripheral on the rp8 I/O peripheral bus (io_*). It is the downstream consumer of core IN/OUT/SBI/CBI accesses and the upstream source of two irq_req lines.
- Provides a 10-bit prescaler, a free-running or clear-on-compare (CTC) counter, overflow and compare flags, and interrupt request/acknowledge.
- The rp8 top ORs io_rdt from all peripherals and maps irq[1:0] into irq_req.

Parameters:
- BASE, 6'h30: I/O address of TCCR. The five registers occupy BASE+0 to BASE+4. BASE+4 must not exceed 6'h3f.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- io_wen  input  1  I/O write enable
- io_ren  input  1  I/O read enable
- io_adr  input  6  I/O address
- io_wdt  input  8  write data
- io_msk  input  8  write bit mask (1 = bit written)
- io_rdt  output  8  registered read data (0 when not addressed)
- irq_req  output  2  [0] overflow, [1] compare match
- irq_ack  input  2  vector-taken acknowledge, per line

Behaviour:
- Register map:
  - +0 TCCR: [2:0] CS, [3] CTC, [7:4] read 0.
  - +1 TCNT.
  - +2 OCR.
  - +3 TIMSK: [0] TOIE, [1] OCIE.
  - +4 TIFR: [0] TOV, [1] OCF.
- Reset: all registers 0x00, prescaler 0, io_rdt 0x00, irq_req 2'b00.
- Masked write for TCCR, TCNT, OCR and TIMSK: reg <= wdt&msk | reg&~msk. Unimplemented bits are ignored.
- TIFR writes are write-one-to-clear: bit i clears when wdt[i]&msk[i]. Writing 0 has no effect.
- Read latency is 1 cycle:
  - io_ren with an address hit: io_rdt <= register value from before any same-cycle write.
  - io_ren with a miss: io_rdt <= 0.
  - No io_ren: io_rdt holds its value.
- Prescaler: a 10-bit counter increments every clk while CS is 1..5 and is held at 0 while CS=0.
  - The tick fires on the cycle where the prescaler's low N bits are all 1.
  - N is 0, 3, 6, 8 or 10 for CS = 1..5, i.e. /1, /8, /64, /256, /1024.
  - CS = 6 or 7 is treated as stopped, the same as CS=0.
  - Any TCCR write that changes CS clears the prescaler in that cycle, and no tick fires that cycle.
- Counter on a tick, evaluated on the current TCNT:
  - CTC=1 and TCNT==OCR: TCNT <= 0 and OCF set. TOV is not set, even when OCR=0xFF.
  - CTC=0 and TCNT==OCR: OCF set and TCNT increments.
  - CTC=0 and TCNT==0xFF: TCNT wraps to 0x00 and TOV is set.
- Same-cycle priority:
  - A CPU write to TCNT overrides the tick increment and suppresses the compare match in that cycle.
  - A flag set by hardware in the same cycle as a W1C clear or irq_ack: set wins.
- irq_req[0] = TOV & TOIE and irq_req[1] = OCF & OCIE. Both are combinational from the registers and carry no extra latency.
- irq_ack[i] clears the corresponding flag on the next edge.
- Reset asserted mid-count returns every register to 0 immediately (asynchronous). Counting resumes only after CS is written nonzero.

Decomposition:
- Package rp8_tmr8_pkg holds:
  - Register offset constants: TCCR=0, TCNT=1, OCR=2, TIMSK=3, TIFR=4.
  - CS enum: STOP, DIV1, DIV8, DIV64, DIV256, DIV1024.
  - Bit-position constants: CTC=3, TOIE/TOV=0, OCIE/OCF=1.
  - A function mapping CS to the prescaler mask.
- One sub-module, rp8_tmr8_presc: 10-bit prescaler with clear input, CS input and tick output.

Test Plan:
- Reset and readback: read BASE+0..+4 → io_rdt = 0x00 one cycle after each io_ren. Read of BASE+5 → 0x00.
- Masked write: TCNT = 0xA5 via wdt=0xFF, msk=0xFF, then wdt=0x00, msk=0x0F → TCNT reads 0xA0. TCCR write of 0xFF reads back 0x0F.
- Overflow at /1: TCNT=0xFE, TIMSK=0x01, TCCR=0x01 → TCNT 0xFF then 0x00 on consecutive cycles. TOV=1 and irq_req=2'b01 after the wrap. irq_ack=2'b01 → TOV=0 next cycle.
- CTC at /8: OCR=0x03, TCCR=0x0A, TIMSK=0x02 → TCNT sequence 0,1,2,3,0 with 8 clk per step. OCF and irq_req[1] set when 3→0. TOV stays 0.
- Priority: tick plus TCNT write of 0x10 in the same cycle → TCNT=0x10 with no compare flag even if OCR=TCNT. OCF set by hardware in the same cycle as a TIFR W1C of 0x02 → OCF=1.
- Prescaler restart: change CS from /64 to /256 mid-count → prescaler 0 and the first tick arrives 256 clk after the write. CS=7 → TCNT frozen.

Source files
------------

// File: rtl/rp8_tmr8_pkg.sv
// rtl/rp8_tmr8_pkg.sv - register map, clock-select codes and helpers for the rp8 timer
package rp8_tmr8_pkg;

  localparam logic [2:0] TCCR  = 3'd0;
  localparam logic [2:0] TCNT  = 3'd1;
  localparam logic [2:0] OCR   = 3'd2;
  localparam logic [2:0] TIMSK = 3'd3;
  localparam logic [2:0] TIFR  = 3'd4;

  localparam int CTC  = 3;
  localparam int TOIE = 0;
  localparam int TOV  = 0;
  localparam int OCIE = 1;
  localparam int OCF  = 1;

  typedef enum logic [2:0] {
    STOP    = 3'd0,
    DIV1    = 3'd1,
    DIV8    = 3'd2,
    DIV64   = 3'd3,
    DIV256  = 3'd4,
    DIV1024 = 3'd5
  } cs_e;

  // Low-bit mask of the prescaler that must be all ones for a tick.
  function automatic logic [9:0] presc_mask(input logic [2:0] cs);
    case (cs)
      DIV1:    return 10'h000;
      DIV8:    return 10'h007;
      DIV64:   return 10'h03f;
      DIV256:  return 10'h0ff;
      DIV1024: return 10'h3ff;
      default: return 10'h000;
    endcase
  endfunction

  // Codes 6 and 7 behave like STOP.
  function automatic logic cs_running(input logic [2:0] cs);
    return (cs >= DIV1) && (cs <= DIV1024);
  endfunction

  function automatic logic [7:0] mwrite(input logic [7:0] cur, input logic [7:0] wdt,
                                        input logic [7:0] msk);
    return (wdt & msk) | (cur & ~msk);
  endfunction

endpackage

// File: rtl/rp8_tmr8_presc.sv
// rtl/rp8_tmr8_presc.sv - 10-bit prescaler producing the timer count tick
module rp8_tmr8_presc
  import rp8_tmr8_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic [2:0] cs,
  output logic       tick
);

  logic [9:0] cnt;
  logic [9:0] mask;
  logic       run;

  assign mask = presc_mask(cs);
  assign run  = cs_running(cs);
  // A clearing cycle never ticks, so a clock-select change restarts a full period.
  assign tick = run && !clr && ((cnt & mask) == mask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 10'h000;
    end else if (clr || !run) begin
      cnt <= 10'h000;
    end else begin
      cnt <= cnt + 10'd1;
    end
  end

endmodule

// File: rtl/rp8_tmr8.sv
// rtl/rp8_tmr8.sv - 8-bit timer/counter on the rp8 I/O bus with overflow and compare interrupts
module rp8_tmr8
  import rp8_tmr8_pkg::*;
#(
  parameter logic [5:0] BASE = 6'h30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       io_wen,
  input  logic       io_ren,
  input  logic [5:0] io_adr,
  input  logic [7:0] io_wdt,
  input  logic [7:0] io_msk,
  output logic [7:0] io_rdt,
  output logic [1:0] irq_req,
  input  logic [1:0] irq_ack
);

  logic [2:0] cs;
  logic       ctc;
  logic [7:0] tcnt;
  logic [7:0] ocr;
  logic       toie;
  logic       ocie;
  logic       tov;
  logic       ocf;

  logic [5:0] off;
  logic [2:0] sel;
  logic       hit;
  logic       wr_tccr;
  logic       wr_tcnt;
  logic       wr_ocr;
  logic       wr_timsk;
  logic       wr_tifr;
  logic [3:0] tccr_new;
  logic [1:0] timsk_new;
  logic [1:0] w1c;
  logic       cs_chg;
  logic       tick;
  logic       match;
  logic       hw_tov;
  logic       hw_ocf;
  logic [7:0] rd_val;

  // Addresses below BASE wrap to large offsets, so one compare covers both bounds.
  assign off = io_adr - BASE;
  assign hit = off < 6'd5;
  assign sel = off[2:0];

  assign wr_tccr  = io_wen && hit && (sel == TCCR);
  assign wr_tcnt  = io_wen && hit && (sel == TCNT);
  assign wr_ocr   = io_wen && hit && (sel == OCR);
  assign wr_timsk = io_wen && hit && (sel == TIMSK);
  assign wr_tifr  = io_wen && hit && (sel == TIFR);

  assign tccr_new  = (io_wdt[3:0] & io_msk[3:0]) | ({ctc, cs} & ~io_msk[3:0]);
  assign timsk_new = (io_wdt[1:0] & io_msk[1:0]) | ({ocie, toie} & ~io_msk[1:0]);
  assign w1c       = wr_tifr ? (io_wdt[1:0] & io_msk[1:0]) : 2'b00;
  assign cs_chg    = wr_tccr && (tccr_new[2:0] != cs);

  rp8_tmr8_presc u_presc (
    .clk  (clk),
    .rst  (rst),
    .clr  (cs_chg),
    .cs   (cs),
    .tick (tick)
  );

  // A CPU write to TCNT takes the whole cycle: no increment and no compare event.
  assign match  = (tcnt == ocr);
  assign hw_ocf = tick && !wr_tcnt && match;
  assign hw_tov = tick && !wr_tcnt && !ctc && (tcnt == 8'hff);

  always_comb begin
    rd_val = 8'h00;
    case (sel)
      TCCR:    rd_val = {4'h0, ctc, cs};
      TCNT:    rd_val = tcnt;
      OCR:     rd_val = ocr;
      TIMSK:   rd_val = {6'h00, ocie, toie};
      TIFR:    rd_val = {6'h00, ocf, tov};
      default: rd_val = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs     <= 3'd0;
      ctc    <= 1'b0;
      tcnt   <= 8'h00;
      ocr    <= 8'h00;
      toie   <= 1'b0;
      ocie   <= 1'b0;
      tov    <= 1'b0;
      ocf    <= 1'b0;
      io_rdt <= 8'h00;
    end else begin
      if (wr_tccr) begin
        cs  <= tccr_new[2:0];
        ctc <= tccr_new[CTC];
      end
      if (wr_ocr) begin
        ocr <= mwrite(ocr, io_wdt, io_msk);
      end
      if (wr_timsk) begin
        toie <= timsk_new[TOIE];
        ocie <= timsk_new[OCIE];
      end
      if (wr_tcnt) begin
        tcnt <= mwrite(tcnt, io_wdt, io_msk);
      end else if (tick) begin
        tcnt <= (ctc && match) ? 8'h00 : tcnt + 8'd1;
      end
      // Hardware set beats a same-cycle software clear or vector acknowledge.
      tov <= hw_tov | (tov & ~(w1c[TOV] | irq_ack[0]));
      ocf <= hw_ocf | (ocf & ~(w1c[OCF] | irq_ack[1]));
      if (io_ren) begin
        io_rdt <= hit ? rd_val : 8'h00;
      end
    end
  end

  assign irq_req = {ocf & ocie, tov & toie};

endmodule
